muldiv_seq: RTL and testbench

- Iterative multi-cycle multiply/divide unit for the execute stage.
- Implements all eight RV32M-style operations, selected by funct3, at a parametrised data width.
- Issued when the ALU control decodes funct7 = 0000001 with Op = 10.
- Valid/ready handshakes on input and output; the pipeline stalls on in_ready / out_valid.

---
 rtl/muldiv_seq.sv | 173 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// muldiv_seq: iterative RV32M-style multiply/divide unit, one result bit per cycle.
// Rev 1.0
module muldiv_seq #(
  parameter int XLEN  = 8,
  parameter int CNT_W = $clog2(XLEN+1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [2:0]       F_MUL    = 3'b000;
  localparam logic [2:0]       F_MULH   = 3'b001;
  localparam logic [2:0]       F_MULHSU = 3'b010;
  localparam logic [2:0]       F_DIV    = 3'b100;
  localparam logic [2:0]       F_REM    = 3'b110;
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(XLEN-1);

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] prod_q, prod_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;   // shifted multiplicand, or divisor in the low half
  logic [XLEN-1:0]   mplier_q, mplier_d; // multiplier, or dividend shifting out / quotient shifting in
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, sa, sb, is_special, b_zero;
  logic [XLEN-1:0]   a_mag, b_mag, special_res;

  assign a_signed = (funct3 == F_MULH) || (funct3 == F_MULHSU) ||
                    (funct3 == F_DIV)  || (funct3 == F_REM);
  assign b_signed = (funct3 == F_MULH) || (funct3 == F_DIV) || (funct3 == F_REM);
  assign sa       = a_signed & op_a[XLEN-1];
  assign sb       = b_signed & op_b[XLEN-1];
  assign a_mag    = sa ? -op_a : op_a;
  assign b_mag    = sb ? -op_b : op_b;
  assign b_zero   = (op_b == '0);
  // funct3[0]==0 among divides marks the signed DIV/REM pair
  assign is_special = funct3[2] &
                      (b_zero | (~funct3[0] & (op_a == MIN_NEG) & (op_b == '1)));
  assign special_res = b_zero ? (funct3[1] ? op_a : '1)
                              : (funct3[1] ? '0 : op_a);

  logic [2*XLEN-1:0] prod_nx, prod_fix;
  logic [XLEN:0]     div_try, div_sub;
  logic              div_ge;
  logic [XLEN-1:0]   quo_nx, rem_nx, quo_fix, rem_fix, final_res;

  assign prod_nx = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign div_try = {rem_q, mplier_q[XLEN-1]};
  assign div_sub = div_try - {1'b0, mcand_q[XLEN-1:0]};
  // no borrow out of the guard bit means the partial remainder covers the divisor
  assign div_ge  = ~div_sub[XLEN];
  assign rem_nx  = div_ge ? div_sub[XLEN-1:0] : div_try[XLEN-1:0];
  assign quo_nx  = {mplier_q[XLEN-2:0], div_ge};

  assign prod_fix  = neg_q ? -prod_nx : prod_nx;
  assign quo_fix   = neg_q ? -quo_nx  : quo_nx;
  assign rem_fix   = neg_q ? -rem_nx  : rem_nx;
  assign final_res = f3_q[2] ? (f3_q[1] ? rem_fix : quo_fix)
                             : ((f3_q == F_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rem_d    = rem_q;
    result_d = result_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            f3_d   = funct3;
            cnt_d  = '0;
            prod_d = '0;
            rem_d  = '0;
            if (funct3[2]) begin
              neg_d    = funct3[1] ? sa : (sa ^ sb);
              mcand_d  = {{XLEN{1'b0}}, b_mag};
              mplier_d = a_mag;
            end else begin
              neg_d    = sa ^ sb;
              mcand_d  = {{XLEN{1'b0}}, a_mag};
              mplier_d = b_mag;
            end
            if (is_special) begin
              result_d = special_res;
              state_d  = DONE;
            end else begin
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          cnt_d = cnt_q + 1'b1;
          if (f3_q[2]) begin
            rem_d    = rem_nx;
            mplier_d = quo_nx;
          end else begin
            prod_d   = prod_nx;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
          end
          if (cnt_q == LAST) begin
            result_d = final_res;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      f3_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rem_q    <= rem_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// tb_muldiv_seq: randomized and directed self-checking bench for muldiv_seq.
// Rev 1.0
module tb_muldiv_seq;

  localparam int W = 8;

  logic         clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b, result;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 0;

  muldiv_seq #(.XLEN(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result straight from the RV32M arithmetic definitions
  function automatic logic [W-1:0] ref_op(input logic [2:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint      x, y, p;
    logic [63:0] pv;
    logic        a_s, b_s;
    a_s = (f == 3'd1) || (f == 3'd2) || (f == 3'd4) || (f == 3'd6);
    b_s = (f == 3'd1) || (f == 3'd4) || (f == 3'd6);
    x = a_s ? longint'($signed(a)) : longint'(a);
    y = b_s ? longint'($signed(b)) : longint'(b);
    if (!f[2]) begin
      p  = x * y;
      pv = p;
      return (f == 3'd0) ? pv[W-1:0] : pv[2*W-1:W];
    end
    if (b == '0) return f[1] ? a : {W{1'b1}};
    if (a_s && x == -(longint'(1) << (W-1)) && y == -1) return f[1] ? '0 : a;
    return f[1] ? W'(x % y) : W'(x / y);
  endfunction

  function automatic bit ref_special(input logic [2:0] f, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    return f[2] && (b == '0 || (!f[0] && a == {1'b1, {(W-1){1'b0}}} && b == '1));
  endfunction

  // Behavioural model: idle / working countdown / holding a result
  int           m_state  = 0;
  int           m_left   = 0;
  logic [W-1:0] m_pend   = '0;
  logic [W-1:0] m_result = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state  <= 0;
      m_left   <= 0;
      m_result <= '0;
    end else if (flush) begin
      m_state <= 0;
    end else begin
      case (m_state)
        0: if (in_valid) begin
          if (ref_special(funct3, op_a, op_b)) begin
            m_result <= ref_op(funct3, op_a, op_b);
            m_state  <= 2;
          end else begin
            m_pend  <= ref_op(funct3, op_a, op_b);
            m_left  <= W;
            m_state <= 1;
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_result <= m_pend;
            m_state  <= 2;
          end
        end
        default: if (out_ready) m_state <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  in_ready,  m_state == 0);
      check("out_valid", out_valid, m_state == 2);
      check("busy",      busy,      m_state != 0);
      check("result",    result,    m_result);
    end
  end

  task automatic run_dir(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_r, input int exp_lat);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    funct3   = f;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    funct3   = 3'($urandom);
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("dir_result", result, exp_r);
    check("dir_latency", lat, exp_lat);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b1, {(W-1){1'b0}}};
      2:       return '1;
      3:       return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  logic [2:0]   d_f   [14] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                               3'd5, 3'd7, 3'd4, 3'd6};
  logic [W-1:0] d_a   [14] = '{8'h07, 8'h07, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'hF9, 8'hF9, 8'hF9,
                               8'hF9, 8'h35, 8'h35, 8'h80, 8'h80};
  logic [W-1:0] d_b   [14] = '{8'hFD, 8'hFD, 8'hFF, 8'hFF, 8'h10, 8'h10, 8'h02, 8'h02, 8'h02,
                               8'h02, 8'h00, 8'h00, 8'hFF, 8'hFF};
  logic [W-1:0] d_exp [14] = '{8'hEB, 8'hFF, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFD, 8'hFF, 8'h7C,
                               8'h01, 8'hFF, 8'h35, 8'h80, 8'h00};
  int           d_lat [14] = '{9, 9, 9, 9, 9, 9, 9, 9, 9, 9, 1, 1, 1, 1};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    bit           saw;
    int           guard;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    check("model_pin_mul",   ref_op(3'd0, 8'h07, 8'hFD), 8'hEB);
    check("model_pin_mulhsu", ref_op(3'd2, 8'hFF, 8'hFF), 8'hFF);
    check("model_pin_div",   ref_op(3'd4, 8'hF9, 8'h02), 8'hFD);

    for (int i = 0; i < 14; i++) run_dir(d_f[i], d_a[i], d_b[i], d_exp[i], d_lat[i]);

    // Backpressure: hold the result for five cycles
    funct3 = 3'd0; op_a = 8'h07; op_b = 8'hFD; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    held = result;
    check("bp_first", held, 8'hEB);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_stable", result, held);
      check("bp_in_ready", in_ready, 0);
      check("bp_busy", busy, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // Flush in the fourth CALC cycle
    funct3 = 3'd4; op_a = 8'h64; op_b = 8'h07; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", in_ready, 1);
    saw = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("flush_no_valid", saw, 0);

    // Asynchronous reset mid-CALC
    funct3 = 3'd1; op_a = 8'h5A; op_b = 8'hC3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_out_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1;
    end
    check("arst_no_valid", saw, 0);
    run_dir(3'd0, 8'h03, 8'h05, 8'h0F, 9);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 1) == 1);
      funct3    = 3'($urandom);
      op_a      = pick();
      op_b      = pick();
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
